vga_timing_gen: RTL

//  Parametrised VGA/DVI raster timing generator, successor to the fixed 640x480 controller.

---
 rtl/vga_timing_gen_pkg.sv | 46 ++++
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/vga_timing_gen_delay_line.sv | 30 +++
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing presets and the control bundle carried alongside pixel fetches.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: vga_axis_t (one axis: active/fp/sync/bp + sync polarity), vga_timing_t (H and V),
//           presets for 640x480@60, 800x600@60, 1280x720@60, vga_ctl_t (delayed control bits).
package vga_pkg;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
      bit          pol;     // sync active level, 1 = active-high
   } vga_axis_t;

   typedef struct packed {
      vga_axis_t h;
      vga_axis_t v;
   } vga_timing_t;

   localparam vga_timing_t VGA_640X480_60 = '{
      h: '{active: 640,  fp: 16,  sync: 96,  bp: 48,  pol: 1'b0},
      v: '{active: 480,  fp: 10,  sync: 2,   bp: 33,  pol: 1'b0}};

   localparam vga_timing_t VGA_800X600_60 = '{
      h: '{active: 800,  fp: 40,  sync: 128, bp: 88,  pol: 1'b1},
      v: '{active: 600,  fp: 1,   sync: 4,   bp: 23,  pol: 1'b1}};

   localparam vga_timing_t VGA_1280X720_60 = '{
      h: '{active: 1280, fp: 110, sync: 40,  bp: 220, pol: 1'b1},
      v: '{active: 720,  fp: 5,   sync: 5,   bp: 20,  pol: 1'b1}};

   // Control bits that travel through the fetch-latency delay line with the raster position.
   typedef struct packed {
      logic line_start;
      logic frame_start;
      logic de;
      logic vs;
      logic hs;
   } vga_ctl_t;

   function automatic int unsigned axis_total(input vga_axis_t a);
      return a.active + a.fp + a.sync + a.bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-fetch request/return plus the video output bundle of the raster generator.
// Latency: n/a (wiring only).
// Backpressure: none; the fetch side must return pixel a fixed latency after pix_req.
// master: generator side (drives requests and video, receives pixel).
// slave:  framebuffer/pin side (receives requests and video, drives pixel).
interface vga_timing_gen_if #(
   parameter int unsigned CW    = 11,
   parameter int unsigned RGB_W = 12
);
   logic             pix_req;
   logic [CW-1:0]    pix_x;
   logic [CW-1:0]    pix_y;
   logic [RGB_W-1:0] pixel;
   logic             hs;
   logic             vs;
   logic             de;
   logic [RGB_W-1:0] rgb;
   logic             frame_start;
   logic             line_start;

   modport master (
      output pix_req, pix_x, pix_y, hs, vs, de, rgb, frame_start, line_start,
      input  pixel
   );

   modport slave (
      input  pix_req, pix_x, pix_y, hs, vs, de, rgb, frame_start, line_start,
      output pixel
   );
endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Enable-gated shift register with synchronous reset to a fixed value.
// Latency: DEPTH enabled ticks from i_dat to o_dat.
// Backpressure: none; i_en=0 freezes every stage.
// Ports: i_clk, i_rst (sync, active-high), i_en (shift enable), i_dat (W in), o_dat (W out).
module vga_delay_line #(
   parameter int unsigned DEPTH   = 1,
   parameter int unsigned W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic [W-1:0] i_dat,
   output logic [W-1:0] o_dat
);

   logic [W-1:0] r_stage [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
      end else if (i_en) begin
         r_stage[0] <= i_dat;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster generator: issues pixel fetches ahead of the raster, realigns sync/DE.
// Latency: hs/vs/de/rgb/pulses for counter position P appear FETCH_LAT+1 pixel ticks after P.
// Backpressure: none; pixel_en=0 holds all state, fetch side must honour FETCH_LAT exactly.
// Ports: i_clk, i_rst (sync, active-high), i_pixel_en (pixel tick),
//        vid (master): pix_req/pix_x/pix_y out, pixel in, hs/vs/de/rgb/frame_start/line_start out.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = VGA_640X480_60.h.active,
   parameter int unsigned H_FP      = VGA_640X480_60.h.fp,
   parameter int unsigned H_SYNC    = VGA_640X480_60.h.sync,
   parameter int unsigned H_BP      = VGA_640X480_60.h.bp,
   parameter int unsigned V_ACTIVE  = VGA_640X480_60.v.active,
   parameter int unsigned V_FP      = VGA_640X480_60.v.fp,
   parameter int unsigned V_SYNC    = VGA_640X480_60.v.sync,
   parameter int unsigned V_BP      = VGA_640X480_60.v.bp,
   parameter bit          HS_POL    = VGA_640X480_60.h.pol,
   parameter bit          VS_POL    = VGA_640X480_60.v.pol,
   parameter int unsigned FETCH_LAT = 1,
   parameter int unsigned RGB_W     = 12,
   parameter int unsigned CW        = 11
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pixel_en,
   vga_timing_gen_if.master vid
);

   localparam int unsigned H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned H_ACT_BEG = H_SYNC + H_BP;
   localparam int unsigned H_ACT_END = H_ACT_BEG + H_ACTIVE;
   localparam int unsigned V_ACT_BEG = V_SYNC + V_BP;
   localparam int unsigned V_ACT_END = V_ACT_BEG + V_ACTIVE;

   localparam vga_ctl_t CTL_IDLE = '{line_start: 1'b0, frame_start: 1'b0, de: 1'b0,
                                     vs: ~VS_POL, hs: ~HS_POL};

   if (FETCH_LAT < 1 || FETCH_LAT > 4) begin : g_bad_fetch_lat
      $error("vga_timing_gen: FETCH_LAT must be in 1..4");
   end
   if (H_TOTAL > (1 << CW) - 1 || V_TOTAL > (1 << CW) - 1) begin : g_bad_cw
      $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
   end

   logic [CW-1:0] r_hcnt;
   logic [CW-1:0] r_vcnt;
   logic          w_h_last;
   logic          w_v_last;
   logic          w_h_act;
   logic          w_v_act;
   logic          w_pix_req;
   vga_ctl_t      w_ctl_raw;
   vga_ctl_t      w_ctl_dly;

   logic             r_hs;
   logic             r_vs;
   logic             r_de;
   logic [RGB_W-1:0] r_rgb;
   logic             r_frame_start;
   logic             r_line_start;

   // ---------------- raster counters ----------------
   assign w_h_last = (r_hcnt == CW'(H_TOTAL - 1));
   assign w_v_last = (r_vcnt == CW'(V_TOTAL - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (i_pixel_en) begin
         if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : r_vcnt + CW'(1);
         end else begin
            r_hcnt <= r_hcnt + CW'(1);
         end
      end
   end

   // ---------------- fetch request (combinational from counters) ----------------
   assign w_h_act   = (r_hcnt >= CW'(H_ACT_BEG)) && (r_hcnt < CW'(H_ACT_END));
   assign w_v_act   = (r_vcnt >= CW'(V_ACT_BEG)) && (r_vcnt < CW'(V_ACT_END));
   assign w_pix_req = w_h_act && w_v_act;

   assign vid.pix_req = w_pix_req;
   assign vid.pix_x   = w_pix_req ? (r_hcnt - CW'(H_ACT_BEG)) : '1;
   assign vid.pix_y   = w_pix_req ? (r_vcnt - CW'(V_ACT_BEG)) : '1;

   // ---------------- raw control decode ----------------
   always_comb begin
      w_ctl_raw             = CTL_IDLE;
      w_ctl_raw.hs          = (r_hcnt < CW'(H_SYNC)) ? HS_POL : ~HS_POL;
      w_ctl_raw.vs          = (r_vcnt < CW'(V_SYNC)) ? VS_POL : ~VS_POL;
      w_ctl_raw.de          = w_pix_req;
      w_ctl_raw.line_start  = (r_hcnt == '0);
      w_ctl_raw.frame_start = (r_hcnt == '0) && (r_vcnt == '0);
   end

   // Control bits wait FETCH_LAT ticks so they line up with the returned pixel.
   vga_delay_line #(
      .DEPTH   (FETCH_LAT),
      .W       ($bits(vga_ctl_t)),
      .RST_VAL (CTL_IDLE)
   ) u_ctl_dly (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (i_pixel_en),
      .i_dat (w_ctl_raw),
      .o_dat (w_ctl_dly)
   );

   // ---------------- output register ----------------
   // Pulses default low every clk so they last one clk even when the next tick is far away.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hs          <= ~HS_POL;
         r_vs          <= ~VS_POL;
         r_de          <= 1'b0;
         r_rgb         <= '0;
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
         if (i_pixel_en) begin
            r_hs          <= w_ctl_dly.hs;
            r_vs          <= w_ctl_dly.vs;
            r_de          <= w_ctl_dly.de;
            r_rgb         <= w_ctl_dly.de ? vid.pixel : '0;
            r_frame_start <= w_ctl_dly.frame_start;
            r_line_start  <= w_ctl_dly.line_start;
         end
      end
   end

   assign vid.hs          = r_hs;
   assign vid.vs          = r_vs;
   assign vid.de          = r_de;
   assign vid.rgb         = r_rgb;
   assign vid.frame_start = r_frame_start;
   assign vid.line_start  = r_line_start;

endmodule
